// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary to packed-BCD converter (shift-and-add-3).
// Converts one input bit per clock. The result registers hold their value
// between conversions, so a downstream display never shows partial values.
//
// Ports:
//   clk      system clock, rising edge
//   rst_i    asynchronous active-high reset
//   bin_i    unsigned binary input, sampled only when a start is accepted
//   start_i  conversion request, level-sampled in IDLE
//   bcd_o    packed BCD result, units digit in [3:0]
//   busy_o   high while a conversion is in progress
//   done_o   one-cycle pulse when bcd_o/ovf_o update
//   ovf_o    last converted value exceeded 10^DIGITS-1 (bcd_o forced to all 9s)
module bin2bcd_seq #(
    parameter int IN_WIDTH = 27,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [IN_WIDTH-1:0]   bin_i,
    input  logic                  start_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    // Largest representable value, 10^DIGITS - 1, computed in 64 bits.
    function automatic logic [63:0] pow10_m1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10_m1(DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t              state, state_n;
    logic [IN_WIDTH-1:0] shift;    // bits still to be shifted in, MSB first
    logic [IN_WIDTH-1:0] bin_q;    // untouched copy for the overflow compare
    logic [BW-1:0]       scratch;
    logic [BW-1:0]       adj;
    logic [CW-1:0]       cnt;
    logic                ovf_n;

    // State register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = CONV;
            CONV:    if (cnt == CW'(1)) state_n = FINISH;  // this edge does the last shift
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    // Add-3 correction: each nibble >= 5 gets +3 before the shift, no
    // carry between nibbles (a corrected nibble is at most 4'hC).
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    // Overflow is decided on the original binary value; scratch may have
    // lost high digits for out-of-range inputs.
    assign ovf_n = (64'(bin_q) > MAX_VAL);

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            shift   <= '0;
            bin_q   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_o   <= '0;
            ovf_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        shift   <= bin_i;
                        bin_q   <= bin_i;
                        scratch <= '0;
                        cnt     <= CW'(IN_WIDTH);
                    end
                end
                CONV: begin
                    // {scratch, shift} shifted left as one register
                    {scratch, shift} <= {adj[BW-2:0], shift, 1'b0};
                    cnt              <= cnt - CW'(1);
                end
                FINISH: begin
                    done_o <= 1'b1;
                    ovf_o  <= ovf_n;
                    bcd_o  <= ovf_n ? {DIGITS{4'h9}} : scratch;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [26:0] bin_i;
    logic        start_i;
    logic [31:0] bcd_o;
    logic        busy_o;
    logic        done_o;
    logic        ovf_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_bcd;   // value bcd_o must hold between conversions
    logic        exp_ovf;

    bin2bcd_seq #(.IN_WIDTH(27), .DIGITS(8)) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .bin_i   (bin_i),
        .start_i (start_i),
        .bcd_o   (bcd_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, saturating to all 9s.
    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        r = '0;
        if (v > 64'd99_999_999) return 32'h9999_9999;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Call at a negedge with the DUT idle. Start is accepted at the next
    // edge; checks latency, busy width, done pulse, result and stability.
    // hold=1 leaves start_i high so the next call is accepted back-to-back.
    task automatic run_conv(input logic [26:0] v, input bit hold);
        int          busy_cnt = 0;
        int          done_cnt = 0;
        int          unstable = 0;
        logic [31:0] want;
        logic        wovf;
        bin_i   = v;
        start_i = 1'b1;
        // sample i is taken after edge k+i-1
        for (int i = 1; i <= 29; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) start_i = 1'b0;
            if (i < 29) begin
                busy_cnt += int'(busy_o);
                done_cnt += int'(done_o);
                if (bcd_o !== exp_bcd || ovf_o !== exp_ovf) unstable++;
            end else begin
                want = ref_bcd(64'(v));
                wovf = (v > 27'd99_999_999);
                chk("done_pulse", 64'(done_o), 64'd1);
                chk("busy_end", 64'(busy_o), 64'd0);
                chk("bcd", 64'(bcd_o), 64'(want));
                chk("ovf", 64'(ovf_o), 64'(wovf));
                chk("busy_cycles", 64'(busy_cnt), 64'd28);
                chk("done_early", 64'(done_cnt), 64'd0);
                chk("bcd_stable", 64'(unstable), 64'd0);
                exp_bcd = want;
                exp_ovf = wovf;
            end
            bin_i = 27'($urandom);   // later changes must not matter
        end
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b0;
        bin_i   = '0;
        exp_bcd = '0;
        exp_ovf = 1'b0;

        // async reset before any clock edge
        #2 rst_i = 1'b1;
        #1;
        chk("rst_bcd", 64'(bcd_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        run_conv(27'd12_345_678, 1'b0);
        run_conv(27'd0, 1'b0);
        run_conv(27'd9, 1'b0);
        run_conv(27'd10, 1'b0);
        run_conv(27'd99_999_999, 1'b0);
        run_conv(27'd100_000_000, 1'b0);
        run_conv(27'd42, 1'b0);
        for (int j = 0; j < 6; j++) run_conv(27'($urandom), 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);

        // start held high, bin_i changing every cycle
        for (int j = 0; j < 4; j++) run_conv(27'($urandom), 1'b1);
        start_i = 1'b0;
        @(negedge clk);
        chk("hold_done_drop", 64'(done_o), 64'd0);

        // reset on the 10th CONV cycle
        bin_i   = 27'd555;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        exp_bcd = '0;
        exp_ovf = 1'b0;
        chk("abort_bcd", 64'(bcd_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_ovf", 64'(ovf_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                seen += int'(done_o) + int'(busy_o);
            end
            chk("abort_no_done", 64'(seen), 64'd0);
        end
        run_conv(27'd7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. Sits directly upstream of the 8-digit seven-segment display driver. Its packed BCD output drives that driver's 32-bit data input, so the display shows decimal instead of hex. Output is held stable between conversions, so the display never shows intermediate values.

Parameters:
IN_WIDTH, 27, width of binary input; 27 bits covers 0..99_999_999.
DIGITS, 8, number of BCD digits; output width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
bin_i  input  IN_WIDTH  unsigned binary value; sampled only when a start is accepted.
start_i  input  1  conversion request; level-sampled each rising edge.
bcd_o  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0], digit DIGITS-1 in the top nibble.
busy_o  output  1  high while a conversion is in progress.
done_o  output  1  one-cycle pulse when bcd_o/ovf_o update.
ovf_o  output  1  high when the last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (async assert, any time including mid-conversion):
  - state=IDLE; bcd_o=0; busy_o=0; done_o=0; ovf_o=0.
  - Internal shift, scratch and count registers are cleared.
  - No done_o pulse is produced for an aborted conversion.
- FSM states: IDLE, CONV, FINISH.
- IDLE:
  - start_i=1 at edge k: latch bin_i into the shift register, clear BCD scratch (4*DIGITS bits), load bit counter=IN_WIDTH, go to CONV.
  - busy_o goes 1 after edge k.
- CONV, each edge:
  - Every scratch nibble >=5 gets +3 (4-bit add, no carry between nibbles).
  - Then {scratch, shift} shifts left by 1 as a single concatenated register, MSB of bin entering scratch bit 0.
  - Counter decrements.
  - The edge performing the IN_WIDTH-th shift (edge k+IN_WIDTH) moves to FINISH.
- FINISH, one edge (k+IN_WIDTH+1), with state->IDLE, busy_o->0 and done_o->1 for exactly one cycle:
  - If latched value <= 10^DIGITS-1: bcd_o=scratch, ovf_o=0.
  - Otherwise: bcd_o = all nibbles 4'h9, ovf_o=1.
  - Overflow compare is done on the latched binary copy, not on scratch.
- Latency: start sampled at edge k -> done_o high and bcd_o valid after edge k+IN_WIDTH+1 (28 clocks at default).
- start_i is ignored in CONV and FINISH; no queueing.
- bin_i changes after acceptance have no effect.
- start_i=1 in the IDLE cycle where done_o=1 is accepted. Back-to-back period is IN_WIDTH+2 clocks (29 at default).
- bcd_o and ovf_o change only on the FINISH edge or on reset; they are stable through CONV.
- done_o is deasserted on every edge except the FINISH edge.
- Width rule: scratch of 4*DIGITS bits is sufficient for every input <= 10^DIGITS-1; overflowed scratch contents are discarded.

Test Plan:
1. Assert rst_i asynchronously between edges -> bcd_o=0, busy_o=0, done_o=0, ovf_o=0 immediately, without waiting for a clock edge.
2. bin_i=12_345_678, one-cycle start_i -> busy_o high for 28 cycles; done_o pulses once at edge k+28; bcd_o=32'h12345678, ovf_o=0.
3. Digit boundaries:
   - 0 -> 32'h00000000.
   - 9 -> 32'h00000009.
   - 10 -> 32'h00000010.
   - 99_999_999 -> 32'h99999999 with ovf_o=0.
4. bin_i=100_000_000 -> bcd_o=32'h99999999, ovf_o=1. A following 42 -> bcd_o=32'h00000042, ovf_o=0.
5. start_i held high while bin_i changes every cycle -> each result equals bin_i at its accept edge; accepts are spaced 29 cycles; bcd_o is constant between done_o pulses.
6. Reset asserted on the 10th CONV cycle -> all outputs 0 and no done_o. After release, convert 7 -> 32'h00000007 after 28 cycles.
